// File: rtl/pattern_player_pkg.sv
// Shared definitions for the pattern_player drum sequencer: state encoding,
// step/instrument geometry and phase-accumulator sizing.
package pattern_player_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int STEPS       = 8;
    localparam int STEP_W      = 3;
    localparam int NUM_INS     = 4;
    localparam int SEC_PER_MIN = 60;
    localparam int PAT_W       = 8;
    // 34 bits hold CLK_HZ*60 plus one 2*bpm increment for CLK_HZ up to 100 MHz.
    localparam int ACC_W       = 34;

endpackage

// File: rtl/pattern_player_beat_timer.sv
// Eighth-note phase accumulator. Adds 2*bpm every enabled cycle and raises
// tick for the cycle in which the running sum crosses CLK_HZ*60. The
// accumulator is held at zero whenever the timer is disabled so every run
// starts from a clean phase.
module beat_timer
    import pattern_player_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] bpm,
    output logic       tick
);

    localparam logic [ACC_W-1:0] THRESH = ACC_W'(64'(CLK_HZ) * 64'(SEC_PER_MIN));

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] inc_s;
    logic [ACC_W-1:0] sum_s;
    logic             wrap_s;

    assign inc_s  = {{(ACC_W - 9){1'b0}}, bpm, 1'b0};
    assign sum_s  = acc_q + inc_s;
    assign wrap_s = (sum_s >= THRESH);
    assign tick   = en & wrap_s;

    // Next accumulator value: cleared when idle, wrapped on a crossing.
    always_comb begin
        acc_d = acc_q;
        if (!en) begin
            acc_d = '0;
        end else if (wrap_s) begin
            acc_d = sum_s - THRESH;
        end else begin
            acc_d = sum_s;
        end
    end

    // Accumulator register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/pattern_player.sv
// Four-instrument, eight-step drum pattern player. Patterns and tempo are
// loaded while idle; while play is held the step counter advances on beat
// timer ticks and each hit fires a PULSE_LEN-cycle trigger pulse.
module pattern_player
    import pattern_player_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int PULSE_LEN = 50_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PAT_W-1:0]    data_in,
    input  logic                ld_ins1,
    input  logic                ld_ins2,
    input  logic                ld_ins3,
    input  logic                ld_ins4,
    input  logic                ld_bpm,
    input  logic                play,
    output logic [NUM_INS-1:0]  trig,
    output logic [STEP_W-1:0]   step,
    output logic                beat_tick
);

    localparam int               CNT_W     = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] PULSE_CNT = CNT_W'(PULSE_LEN);

    state_e                            state_q, state_d;
    logic [STEP_W-1:0]                 step_q, step_d;
    logic                              beat_tick_q, beat_tick_d;
    logic [NUM_INS-1:0][PAT_W-1:0]     pat_q, pat_d;
    logic [PAT_W-1:0]                  bpm_q, bpm_d;
    logic [NUM_INS-1:0][CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_INS-1:0]                trig_q, trig_d;
    logic [NUM_INS-1:0]                hit_s;
    logic [NUM_INS-1:0]                ld_ins_s;
    logic                              run_en_s;
    logic                              tick_s;

    assign ld_ins_s = {ld_ins4, ld_ins3, ld_ins2, ld_ins1};
    // Sequencing is live only while running with play still held; a play
    // drop clears everything on the same edge it is seen.
    assign run_en_s = (state_q == ST_RUN) && play;

    beat_timer #(
        .CLK_HZ (CLK_HZ)
    ) u_beat_timer (
        .clk   (clk),
        .reset (reset),
        .en    (run_en_s),
        .bpm   (bpm_q),
        .tick  (tick_s)
    );

    // FSM next state, register loads, step advance and beat tick.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        beat_tick_d = 1'b0;
        pat_d       = pat_q;
        bpm_d       = bpm_q;
        case (state_q)
            ST_IDLE: begin
                for (int i = 0; i < NUM_INS; i++) begin
                    if (ld_ins_s[i]) begin
                        pat_d[i] = data_in;
                    end else begin
                        pat_d[i] = pat_q[i];
                    end
                end
                if (ld_bpm) begin
                    bpm_d = data_in;
                end else begin
                    bpm_d = bpm_q;
                end
                if (play) begin
                    state_d     = ST_RUN;
                    step_d      = '0;
                    beat_tick_d = 1'b1;
                end else begin
                    state_d     = ST_IDLE;
                    step_d      = '0;
                end
            end
            ST_RUN: begin
                if (!play) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end else if (tick_s) begin
                    step_d      = step_q + STEP_W'(1);
                    beat_tick_d = 1'b1;
                end else begin
                    step_d      = step_q;
                    beat_tick_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Per-instrument pulse stretchers: a hit on the cycle after a step entry
    // (re)loads the counter, which then counts the pulse down to zero.
    always_comb begin
        hit_s  = '0;
        cnt_d  = cnt_q;
        trig_d = '0;
        for (int i = 0; i < NUM_INS; i++) begin
            hit_s[i] = beat_tick_q & pat_q[i][step_q];
            if (!run_en_s) begin
                cnt_d[i] = '0;
            end else if (hit_s[i]) begin
                cnt_d[i] = PULSE_CNT;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            trig_d[i] = (cnt_d[i] != '0);
        end
    end

    // State and datapath registers; reset wins over play and loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            beat_tick_q <= 1'b0;
            pat_q       <= '0;
            bpm_q       <= '0;
            cnt_q       <= '0;
            trig_q      <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            beat_tick_q <= beat_tick_d;
            pat_q       <= pat_d;
            bpm_q       <= bpm_d;
            cnt_q       <= cnt_d;
            trig_q      <= trig_d;
        end
    end

    assign trig      = trig_q;
    assign step      = step_q;
    assign beat_tick = beat_tick_q;

endmodule

// File: tb/tb_pattern_player.sv
// Self-checking bench for pattern_player (CLK_HZ=2, PULSE_LEN=3, so a step
// advances once the accumulated 2*bpm reaches 120). A behavioural model
// predicts every cycle's outputs into a queue; a negedge monitor compares.
module tb_pattern_player;

    localparam int  PL  = 3;
    localparam longint THR = 120;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       ld_ins1, ld_ins2, ld_ins3, ld_ins4, ld_bpm, play;
    logic [3:0] trig;
    logic [2:0] step;
    logic       beat_tick;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] step;
        logic       bt;
        logic [3:0] trig;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // behavioural model state
    bit         m_run = 1'b0;
    logic [7:0] m_pat [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    longint     m_bpm = 0;
    longint     m_acc = 0;
    int         m_step = 0;
    bit         m_bt = 1'b0;
    int         m_cnt [4] = '{0, 0, 0, 0};

    pattern_player #(
        .CLK_HZ    (2),
        .PULSE_LEN (PL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .ld_ins1   (ld_ins1),
        .ld_ins2   (ld_ins2),
        .ld_ins3   (ld_ins3),
        .ld_ins4   (ld_ins4),
        .ld_bpm    (ld_bpm),
        .play      (play),
        .trig      (trig),
        .step      (step),
        .beat_tick (beat_tick)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: one expectation per rising edge, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (step !== mon_e.step) begin
                errors++;
                $display("FAIL sb_step: got %0d expected %0d at %0t", step, mon_e.step, $time);
            end
            checks++;
            if (beat_tick !== mon_e.bt) begin
                errors++;
                $display("FAIL sb_beat_tick: got %0b expected %0b at %0t", beat_tick, mon_e.bt, $time);
            end
            checks++;
            if (trig !== mon_e.trig) begin
                errors++;
                $display("FAIL sb_trig: got %b expected %b at %0t", trig, mon_e.trig, $time);
            end
        end
    end

    // Apply the current inputs to the model as of the next rising edge.
    task automatic model_eval();
        logic [3:0] t;
        logic [7:0] ld;
        if (reset) begin
            m_run = 1'b0; m_bpm = 0; m_acc = 0; m_step = 0; m_bt = 1'b0;
            for (int i = 0; i < 4; i++) begin m_pat[i] = 8'h00; m_cnt[i] = 0; end
        end else if (!m_run) begin
            ld = {4'b0000, ld_ins4, ld_ins3, ld_ins2, ld_ins1};
            for (int i = 0; i < 4; i++) if (ld[i]) m_pat[i] = data_in;
            if (ld_bpm) m_bpm = longint'(data_in);
            m_acc = 0;
            m_step = 0;
            m_bt = play;
            m_run = play;
        end else if (!play) begin
            m_run = 1'b0; m_acc = 0; m_step = 0; m_bt = 1'b0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_bt && m_pat[i][m_step]) m_cnt[i] = PL;
                else if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            end
            m_acc = m_acc + 2 * m_bpm;
            if (m_acc >= THR) begin
                m_acc = m_acc - THR;
                m_step = (m_step + 1) % 8;
                m_bt = 1'b1;
            end else begin
                m_bt = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) t[i] = (m_cnt[i] > 0);
        exp_q.push_back('{step: 3'(m_step), bt: m_bt, trig: t});
    endtask

    // One clock with the current inputs; returns 1 time unit after the edge.
    task automatic cyc();
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val, input logic [4:0] sel);
        data_in = val;
        {ld_bpm, ld_ins4, ld_ins3, ld_ins2, ld_ins1} = sel;
        cyc();
        {ld_bpm, ld_ins4, ld_ins3, ld_ins2, ld_ins1} = 5'b00000;
    endtask

    task automatic test_reset();
        int bt_cnt;
        int trig_cnt;
        reset = 1'b1; play = 1'b1; ld_ins1 = 1'b1; ld_bpm = 1'b1; data_in = 8'hFF;
        cyc();
        cyc();
        checks++;
        if ({step, beat_tick, trig} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 00", {step, beat_tick, trig});
        end
        reset = 1'b0; ld_ins1 = 1'b0; ld_bpm = 1'b0;
        bt_cnt = 0; trig_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            bt_cnt += int'(beat_tick);
            if (trig != 4'h0) trig_cnt++;
        end
        checks++;
        if (bt_cnt !== 1) begin
            errors++;
            $display("FAIL reset_bpm0_ticks: got %0d expected 1", bt_cnt);
        end
        checks++;
        if (trig_cnt !== 0) begin
            errors++;
            $display("FAIL reset_patterns_cleared: got %0d trig cycles expected 0", trig_cnt);
        end
        play = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        int t0_cnt;
        load(8'h01, 5'b00001);
        load(8'h80, 5'b00010);
        load(8'd60, 5'b10000);
        play = 1'b1;
        cyc();
        checks++;
        if ({step, beat_tick} !== 4'b0001) begin
            errors++;
            $display("FAIL basic_start: got step %0d tick %0b expected 0 1", step, beat_tick);
        end
        t0_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k <= 8) t0_cnt += int'(trig[0]);
            if (k == 8) begin
                checks++;
                if ({step, trig[1]} !== 4'b0001) begin
                    errors++;
                    $display("FAIL basic_wrap: got step %0d trig1 %0b expected 0 1", step, trig[1]);
                end
            end
        end
        checks++;
        if (t0_cnt !== PL) begin
            errors++;
            $display("FAIL basic_pulse_len: got %0d expected %0d", t0_cnt, PL);
        end
        play = 1'b0;
        cyc();
        checks++;
        if ({step, beat_tick, trig} !== 8'h00) begin
            errors++;
            $display("FAIL basic_stop_clear: got %h expected 00", {step, beat_tick, trig});
        end
    endtask

    task automatic test_retrigger();
        int low_cnt;
        int diff_cnt;
        load(8'd30, 5'b10000);
        load(8'hFF, 5'b01100);
        play = 1'b1;
        cyc();
        low_cnt = 0; diff_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (!trig[2]) low_cnt++;
            if (trig[3] !== trig[2]) diff_cnt++;
            if (k == 4) begin
                checks++;
                if (step !== 3'd2) begin
                    errors++;
                    $display("FAIL retrig_step_rate: got %0d expected 2", step);
                end
            end
        end
        checks++;
        if (low_cnt !== 0) begin
            errors++;
            $display("FAIL retrig_continuous: got %0d low cycles expected 0", low_cnt);
        end
        checks++;
        if (diff_cnt !== 0) begin
            errors++;
            $display("FAIL multi_load: got %0d differing cycles expected 0", diff_cnt);
        end
        play = 1'b0;
        cyc();
    endtask

    task automatic test_bpm_zero();
        int bt_cnt;
        int moved;
        int t0_cnt;
        load(8'd0, 5'b10000);
        play = 1'b1;
        bt_cnt = 0; moved = 0; t0_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            bt_cnt += int'(beat_tick);
            if (step != 3'd0) moved++;
            t0_cnt += int'(trig[0]);
        end
        checks++;
        if (bt_cnt !== 1) begin
            errors++;
            $display("FAIL bpm0_ticks: got %0d expected 1", bt_cnt);
        end
        checks++;
        if (moved !== 0) begin
            errors++;
            $display("FAIL bpm0_step_frozen: got %0d moved cycles expected 0", moved);
        end
        checks++;
        if (t0_cnt !== PL) begin
            errors++;
            $display("FAIL bpm0_single_hit: got %0d expected %0d", t0_cnt, PL);
        end
        play = 1'b0;
        cyc();
    endtask

    task automatic test_load_in_run();
        int t0_cnt;
        int low_cnt;
        load(8'h00, 5'b01100);
        load(8'd60, 5'b10000);
        play = 1'b1;
        cyc();
        t0_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            data_in = 8'hFF;
            ld_ins1 = (k == 1);
            cyc();
            t0_cnt += int'(trig[0]);
        end
        ld_ins1 = 1'b0;
        checks++;
        if (t0_cnt !== PL) begin
            errors++;
            $display("FAIL run_load_ignored: got %0d expected %0d", t0_cnt, PL);
        end
        play = 1'b0;
        cyc();
        load(8'hFF, 5'b00001);
        play = 1'b1;
        cyc();
        low_cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            if (!trig[0]) low_cnt++;
        end
        checks++;
        if (low_cnt !== 0) begin
            errors++;
            $display("FAIL idle_reload_used: got %0d low cycles expected 0", low_cnt);
        end
        play = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_run();
        int trig_cnt;
        play = 1'b1;
        cyc();
        for (int k = 1; k <= 5; k++) cyc();
        checks++;
        if ({step, trig[0]} !== 4'b1011) begin
            errors++;
            $display("FAIL midrun_setup: got step %0d trig0 %0b expected 5 1", step, trig[0]);
        end
        reset = 1'b1;
        cyc();
        checks++;
        if ({step, beat_tick, trig} !== 8'h00) begin
            errors++;
            $display("FAIL midrun_reset: got %h expected 00", {step, beat_tick, trig});
        end
        reset = 1'b0; play = 1'b0;
        cyc();
        load(8'd60, 5'b10000);
        play = 1'b1;
        trig_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (trig != 4'h0) trig_cnt++;
        end
        checks++;
        if (trig_cnt !== 0) begin
            errors++;
            $display("FAIL midrun_patterns_cleared: got %0d expected 0", trig_cnt);
        end
        play = 1'b0;
        cyc();
    endtask

    task automatic test_stop_restart();
        load(8'h01, 5'b00001);
        load(8'h08, 5'b00010);
        play = 1'b1;
        cyc();
        for (int k = 1; k <= 3; k++) cyc();
        play = 1'b0;
        cyc();
        checks++;
        if ({step, beat_tick, trig} !== 8'h00) begin
            errors++;
            $display("FAIL stop_at_3: got %h expected 00", {step, beat_tick, trig});
        end
        play = 1'b1;
        cyc();
        checks++;
        if ({step, beat_tick} !== 4'b0001) begin
            errors++;
            $display("FAIL restart_tick: got step %0d tick %0b expected 0 1", step, beat_tick);
        end
        cyc();
        checks++;
        if (trig !== 4'b0001) begin
            errors++;
            $display("FAIL restart_retained: got %b expected 0001", trig);
        end
        for (int k = 2; k <= 6; k++) cyc();
        play = 1'b0;
        cyc();
    endtask

    initial begin
        reset = 1'b1; data_in = 8'h00; play = 1'b0;
        ld_ins1 = 1'b0; ld_ins2 = 1'b0; ld_ins3 = 1'b0; ld_ins4 = 1'b0; ld_bpm = 1'b0;
        test_reset();
        test_basic();
        test_retrigger();
        test_bpm_zero();
        test_load_in_run();
        test_reset_mid_run();
        test_stop_restart();
        cyc();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
